pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
Parametrised program-counter unit for the pipelined MIPS core, one generation on from the plain PC register. It holds the fetch PC and selects the next PC by fixed priority: exception vector, EX-stage redirect, jump target, return-address-stack pop, or sequential increment. It keeps a small circular return-address stack (RAS) so `jr $ra` can be predicted at fetch. It sits at the front of the IF stage, drives the instruction-memory address and feeds `pc_plus_inc` to the IF/ID register.

Parameters:
WIDTH, 32, PC and address width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
INC, 4, sequential increment in bytes.
RAS_DEPTH, 4, RAS entries (power of two, >= 2).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc_write  input  1  1 = PC may advance; 0 = stall, hold PC.
exc_valid  input  1  exception taken; load EXC_VECTOR.
redirect_valid  input  1  EX-stage branch/jr mispredict correction.
redirect_pc  input  WIDTH  corrected target.
jump_valid  input  1  j/jal decoded in ID.
jump_target  input  WIDTH  j/jal target.
call_push  input  1  jal seen; push ret_addr onto the RAS.
ret_addr  input  WIDTH  return address to push.
ret_pop  input  1  jr $ra predicted; next PC = RAS top.
pc_out  output  WIDTH  current fetch PC.
pc_plus_inc  output  WIDTH  pc_out + INC, combinational.
ras_top  output  WIDTH  current RAS top entry (0 when empty).
ras_empty  output  1  RAS count == 0.
ras_full  output  1  RAS count == RAS_DEPTH.
misalign_err  output  1  see Optional Feature; constant 0 when the feature is compiled out.

Behaviour:
- Reset (async, any time, including mid-push/pop): pc_out = RESET_VECTOR, RAS count = 0, RAS pointer = 0, every RAS entry = 0, misalign_err = 0. The first edge after rst deasserts follows normal rules.
- Next-PC priority at each rising edge:
  - exc_valid: load EXC_VECTOR.
  - redirect_valid: load redirect_pc.
  - pc_write == 0: hold.
  - jump_valid: load jump_target.
  - ret_pop with RAS non-empty: load ras_top.
  - Otherwise: load pc_out + INC.
- exc_valid and redirect_valid ignore pc_write; a flush overrides a stall.
- pc_out + INC wraps modulo 2^WIDTH. No saturation.
- Latency: pc_out takes the selected value one cycle after the inputs are sampled. ras_top, ras_empty and ras_full reflect the updated RAS in the same cycle pc_out updates.
- A RAS operation is effective only if pc_write == 1, exc_valid == 0 and redirect_valid == 0. Otherwise the RAS is unchanged.
- Push (call_push only): write ret_addr at ptr+1 (mod RAS_DEPTH), advance ptr, count = min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten (circular) and ras_full stays 1.
- Pop (ret_pop only, RAS non-empty): ptr-1 (mod RAS_DEPTH), count-1.
- Pop on empty RAS: no RAS change; next PC = pc_out + INC.
- call_push and ret_pop together: replace the top entry with ret_addr; ptr and count unchanged; next PC = the old ras_top. On an empty RAS this is a plain push with sequential next PC.
- jump_valid together with ret_pop: jump wins. The pop is suppressed; a call_push in the same cycle still takes effect.
- ras_top is the entry at ptr when count > 0, else 0.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: if the selected next PC has bits [1:0] != 0 and exc_valid == 0, load EXC_VECTOR instead.
  - misalign_err is registered and pulses high for exactly the one cycle in which pc_out == EXC_VECTOR because of the trap.
  - RAS operations for that cycle are suppressed.
- Not defined: no check; a misaligned target loads as-is; misalign_err is tied to 0.

Test Plan:
- Reset and sequential fetch: rst pulse, then 3 free-running cycles -> pc_out 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- Stall vs flush:
  - pc_out=0x10, pc_write=0 for 2 cycles -> holds 0x10.
  - Then pc_write=0 with redirect_valid=1, redirect_pc=0x40 -> pc_out=0x40 next cycle.
- Call/return:
  - jump_valid=1, jump_target=0x100, call_push=1, ret_addr=0x24 -> pc_out=0x100, ras_top=0x24.
  - Later ret_pop=1 -> pc_out=0x24, ras_empty=1.
- RAS overflow, RAS_DEPTH=4: push 0xA0, 0xA4, 0xA8, 0xAC, 0xB0 -> ras_full=1, ras_top=0xB0. Four pops return 0xB0, 0xAC, 0xA8, 0xA4; a fifth pop gives sequential PC and ras_empty=1.
- Priority and reset: exc_valid=1, redirect_valid=1, jump_valid=1 in one cycle -> pc_out=0x80000180, RAS unchanged. Assert rst mid-cycle during a push -> pc_out=0x0 immediately and ras_empty=1.
- PC_ALIGN_CHECK_EN defined: redirect_pc=0x102 -> pc_out=0x80000180 and misalign_err=1 for one cycle. Compiled out: pc_out=0x102 and misalign_err=0.

Source files
------------

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch program counter with prioritised next-PC selection and a
// small circular return-address stack (RAS) for predicting `jr $ra`.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   pc_write              1 = PC may advance, 0 = stall (hold)
//   exc_valid             exception taken, load EXC_VECTOR (overrides stall)
//   redirect_valid/_pc    EX-stage mispredict correction (overrides stall)
//   jump_valid/_target    j/jal decoded in ID
//   call_push, ret_addr   push a return address onto the RAS
//   ret_pop               predicted return, next PC = RAS top
//   pc_out                current fetch PC
//   pc_plus_inc           pc_out + INC (combinational, wraps)
//   ras_top/empty/full    RAS status (ras_top is 0 when empty)
//   misalign_err          one-cycle pulse on an alignment trap
//
// Build option: define PC_ALIGN_CHECK_EN to trap misaligned next-PC values to
// EXC_VECTOR; when undefined misalign_err is tied to 0.

module pc_seq_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             exc_valid,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call_push,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign_err
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] sel_pc;
  logic             ras_en;
  logic             pop_eff;
  logic             trap;

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_q + WIDTH'(INC);
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top     = ras_empty ? '0 : ras_q[ptr_q];

  // A pop only counts when the RAS has an entry and no jump outranks it.
  assign pop_eff = ret_pop && !jump_valid && !ras_empty;

  // Fixed-priority next-PC select.
  always_comb begin
    sel_pc = pc_plus_inc;
    if (exc_valid)           sel_pc = EXC_VECTOR;
    else if (redirect_valid) sel_pc = redirect_pc;
    else if (!pc_write)      sel_pc = pc_q;
    else if (jump_valid)     sel_pc = jump_target;
    else if (pop_eff)        sel_pc = ras_top;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign trap         = (sel_pc[1:0] != 2'b00) && !exc_valid;
  assign misalign_d   = trap;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign pc_d   = trap ? EXC_VECTOR : sel_pc;
  assign ras_en = pc_write && !exc_valid && !redirect_valid && !trap;

  // RAS update: push, pop, or replace-top when push and pop coincide.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    if (ras_en) begin
      if (call_push && pop_eff) begin
        ras_d[ptr_q] = ret_addr;
      end else if (call_push) begin
        ptr_d        = ptr_q + PTR_W'(1);
        ras_d[ptr_d] = ret_addr;
        if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_eff) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed testbench for pc_seq_unit (default parameters).
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, exc_valid, redirect_valid, jump_valid, call_push, ret_pop;
  logic [31:0] redirect_pc, jump_target, ret_addr;
  logic [31:0] pc_out, pc_plus_inc, ras_top;
  logic        ras_empty, ras_full, misalign_err;

  int n_vec = 0;
  int n_err = 0;

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .exc_valid(exc_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .call_push(call_push), .ret_addr(ret_addr), .ret_pop(ret_pop),
    .pc_out(pc_out), .pc_plus_inc(pc_plus_inc), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    pc_write = 1'b1; exc_valid = 1'b0; redirect_valid = 1'b0; jump_valid = 1'b0;
    call_push = 1'b0; ret_pop = 1'b0;
    redirect_pc = '0; jump_target = '0; ret_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] exp_pc);
    idle(); call_push = 1'b1; ret_addr = a;
    step();
    chk("push_pc", pc_out, exp_pc);
    chk("push_top", ras_top, a);
  endtask

  task automatic pop(input logic [31:0] exp_pc, input logic exp_empty);
    idle(); ret_pop = 1'b1;
    step();
    chk("pop_pc", pc_out, exp_pc);
    chk("pop_empty", 32'(ras_empty), 32'(exp_empty));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_top", ras_top, 32'h0);
    chk("rst_inc", pc_plus_inc, 32'h4);
    chk("rst_mis", 32'(misalign_err), 32'd0);

    // Sequential fetch
    step(); chk("seq1", pc_out, 32'h4);
    step(); chk("seq2", pc_out, 32'h8);
    step(); chk("seq3", pc_out, 32'hC);
    step(); chk("seq4", pc_out, 32'h10);
    chk("seq_empty", 32'(ras_empty), 32'd1);

    // Stall, then flush overriding stall
    pc_write = 1'b0;
    step(); chk("stall1", pc_out, 32'h10);
    step(); chk("stall2", pc_out, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); chk("flush", pc_out, 32'h40);

    // Call via jal, then return
    idle(); jump_valid = 1'b1; jump_target = 32'h100; call_push = 1'b1; ret_addr = 32'h24;
    step(); chk("jal_pc", pc_out, 32'h100); chk("jal_top", ras_top, 32'h24);
    chk("jal_empty", 32'(ras_empty), 32'd0);
    idle(); step(); chk("body", pc_out, 32'h104);
    pop(32'h24, 1'b1);
    pop(32'h28, 1'b1);  // pop on empty: sequential

    // Overflow: five pushes into a depth-4 stack
    push(32'hA0, 32'h2C);
    push(32'hA4, 32'h30);
    push(32'hA8, 32'h34);
    push(32'hAC, 32'h38);
    chk("full4", 32'(ras_full), 32'd1);
    push(32'hB0, 32'h3C);
    chk("full5", 32'(ras_full), 32'd1);
    pop(32'hB0, 1'b0);
    pop(32'hAC, 1'b0);
    pop(32'hA8, 1'b0);
    pop(32'hA4, 1'b1);
    pop(32'hA8, 1'b1);

    // Push + pop together replaces top, next PC is old top
    push(32'h200, 32'hAC);
    push(32'h300, 32'hB0);
    idle(); call_push = 1'b1; ret_pop = 1'b1; ret_addr = 32'h400;
    step(); chk("swap_pc", pc_out, 32'h300); chk("swap_top", ras_top, 32'h400);
    pop(32'h400, 1'b0);
    chk("swap_under", ras_top, 32'h200);

    // Jump beats pop
    idle(); jump_valid = 1'b1; jump_target = 32'h500; ret_pop = 1'b1;
    step(); chk("jpop_pc", pc_out, 32'h500); chk("jpop_top", ras_top, 32'h200);

    // Stalled pop does nothing
    idle(); pc_write = 1'b0; ret_pop = 1'b1;
    step(); chk("spop_pc", pc_out, 32'h500); chk("spop_top", ras_top, 32'h200);

    // Priority: exception beats everything, RAS untouched
    idle(); exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h600;
    jump_valid = 1'b1; jump_target = 32'h700; call_push = 1'b1; ret_addr = 32'h900;
    step(); chk("exc_pc", pc_out, 32'h8000_0180); chk("exc_top", ras_top, 32'h200);
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h1000; ret_pop = 1'b1;
    step(); chk("redir_pc", pc_out, 32'h1000); chk("redir_top", ras_top, 32'h200);

    // Wrap modulo 2^32
    idle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk("wrap_pc", pc_out, 32'hFFFF_FFFC); chk("wrap_inc", pc_plus_inc, 32'h0);
    idle(); step(); chk("wrap_seq", pc_out, 32'h0);

    // Misaligned redirect
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", pc_out, 32'h8000_0180); chk("mis_err", 32'(misalign_err), 32'd1);
    idle(); step();
    chk("mis_pc2", pc_out, 32'h8000_0184); chk("mis_err2", 32'(misalign_err), 32'd0);
`else
    chk("mis_pc", pc_out, 32'h102); chk("mis_err", 32'(misalign_err), 32'd0);
    idle(); step();
    chk("mis_pc2", pc_out, 32'h106); chk("mis_err2", 32'(misalign_err), 32'd0);
`endif

    // Asynchronous reset right after a push edge
    idle(); call_push = 1'b1; ret_addr = 32'h44;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_empty", 32'(ras_empty), 32'd1);
    chk("arst_top", ras_top, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    step(); chk("post_rst", pc_out, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
